jtvigil_romarb: RTL and testbench

- Shares one external ROM/SDRAM read port among three graphics requesters: slot 0 = scroll 1, slot 1 = scroll 2, slot 2 = objects.
- Each requester uses the cs/addr/data/ok handshake expected by the scroll and object tile fetchers.
- Each slot has a one-word cache, so a requester that holds its address gets ok without new port traffic.
- Misses are serviced one at a time through a round-robin arbiter.

---
 rtl/jtvigil_romarb_if.sv | 22 ++
 rtl/jtvigil_romarb.sv | 96 +++++++++
 tb/tb_jtvigil_romarb.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/jtvigil_romarb_if.sv
// jtvigil_romarb_if: three tile-fetch requester ports plus the shared ROM read port
interface jtvigil_romarb_if #(
    parameter int AW  = 18,
    parameter int OAW = 22
);
    logic           r0_cs, r1_cs, r2_cs;
    logic [AW-1:0]  r0_addr, r1_addr, r2_addr;
    logic [31:0]    r0_data, r1_data, r2_data;
    logic           r0_ok, r1_ok, r2_ok;
    logic [OAW-1:0] sd_addr;
    logic           sd_rd, sd_ack, sd_rdy;
    logic [31:0]    sd_data;

    modport slave (
        input  r0_cs, r1_cs, r2_cs, r0_addr, r1_addr, r2_addr, sd_ack, sd_rdy, sd_data,
        output r0_data, r1_data, r2_data, r0_ok, r1_ok, r2_ok, sd_addr, sd_rd
    );
    modport master (
        output r0_cs, r1_cs, r2_cs, r0_addr, r1_addr, r2_addr, sd_ack, sd_rdy, sd_data,
        input  r0_data, r1_data, r2_data, r0_ok, r1_ok, r2_ok, sd_addr, sd_rd
    );
endinterface

// File: rtl/jtvigil_romarb.sv
// jtvigil_romarb: round-robin arbiter with one-word caches sharing a ROM read port among three requesters
module jtvigil_romarb #(
    parameter int             AW   = 18,
    parameter int             OAW  = 22,
    parameter logic [OAW-1:0] OFS0 = '0,
    parameter logic [OAW-1:0] OFS1 = OAW'(22'h40000),
    parameter logic [OAW-1:0] OFS2 = OAW'(22'h80000)
)(
    input logic rst,
    input logic clk,
    jtvigil_romarb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t         r_st;
    logic [AW-1:0]  r_caddr[3];
    logic [31:0]    r_cdata[3];
    logic [2:0]     r_valid;
    logic [1:0]     r_owner, r_ptr;
    logic [AW-1:0]  r_faddr;
    logic [OAW-1:0] r_sd_addr;
    logic           r_sd_rd;

    logic [2:0]     w_cs, w_hit, w_busy, w_miss;
    logic [AW-1:0]  w_addr[3];
    logic [OAW-1:0] w_ofs[3];
    logic [1:0]     w_n1, w_n2, w_win;
    logic           w_fill;

    assign w_cs      = {bus.r2_cs, bus.r1_cs, bus.r0_cs};
    assign w_addr[0] = bus.r0_addr;
    assign w_addr[1] = bus.r1_addr;
    assign w_addr[2] = bus.r2_addr;
    assign w_ofs[0]  = OFS0;
    assign w_ofs[1]  = OFS1;
    assign w_ofs[2]  = OFS2;

    for (genvar i = 0; i < 3; i++) begin : g_hit
        assign w_hit[i] = r_valid[i] & (w_addr[i] == r_caddr[i]);
    end

    // the in-flight slot cannot miss again until its (possibly stale) fill lands
    assign w_busy = r_st == IDLE ? 3'b000 : 3'b001 << r_owner;
    assign w_miss = w_cs & ~w_hit & ~w_busy;
    assign w_n1   = r_ptr == 2'd2 ? 2'd0 : r_ptr + 2'd1;
    assign w_n2   = w_n1 == 2'd2 ? 2'd0 : w_n1 + 2'd1;
    assign w_win  = w_miss[w_n1] ? w_n1 : w_miss[w_n2] ? w_n2 : r_ptr;
    assign w_fill = bus.sd_rdy & ((r_st == REQ & bus.sd_ack) | r_st == WAIT);

    assign bus.r0_ok   = w_cs[0] & w_hit[0];
    assign bus.r1_ok   = w_cs[1] & w_hit[1];
    assign bus.r2_ok   = w_cs[2] & w_hit[2];
    assign bus.r0_data = r_cdata[0];
    assign bus.r1_data = r_cdata[1];
    assign bus.r2_data = r_cdata[2];
    assign bus.sd_addr = r_sd_addr;
    assign bus.sd_rd   = r_sd_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st      <= IDLE;
            r_valid   <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_faddr   <= '0;
            r_sd_addr <= '0;
            r_sd_rd   <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                r_caddr[k] <= '0;
                r_cdata[k] <= '0;
            end
        end else begin
            if (w_fill) begin
                r_cdata[r_owner] <= bus.sd_data;
                r_caddr[r_owner] <= r_faddr;
                r_valid[r_owner] <= 1'b1;
            end
            case (r_st)
                IDLE: if (|w_miss) begin
                    r_owner   <= w_win;
                    r_ptr     <= w_win;
                    r_faddr   <= w_addr[w_win];
                    r_sd_addr <= OAW'(w_addr[w_win]) + w_ofs[w_win];
                    r_sd_rd   <= 1'b1;
                    r_st      <= REQ;
                end
                REQ: if (bus.sd_ack) begin
                    r_sd_rd <= 1'b0;
                    r_st    <= bus.sd_rdy ? IDLE : WAIT;
                end
                WAIT: if (bus.sd_rdy) r_st <= IDLE;
                default: r_st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtvigil_romarb.sv
// tb_jtvigil_romarb: scoreboard bench, expected fetches queued at stimulus and checked as the port serves them
module tb_jtvigil_romarb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   n;

    typedef struct {
        logic [1:0]  slot;
        logic [21:0] addr;
        logic [31:0] data;
        logic [2:0]  okv;
    } ent_t;

    ent_t q[$];
    ent_t e;

    jtvigil_romarb_if #(.AW(18), .OAW(22)) bus();
    jtvigil_romarb dut (.rst(rst), .clk(clk), .bus(bus));

    logic [2:0]  ok;
    logic [31:0] dat[3];
    assign ok     = {bus.r2_ok, bus.r1_ok, bus.r0_ok};
    assign dat[0] = bus.r0_data;
    assign dat[1] = bus.r1_data;
    assign dat[2] = bus.r2_data;

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] slot, input logic [21:0] addr, input logic [31:0] data, input logic [2:0] okv);
        ent_t x;
        x.slot = slot;
        x.addr = addr;
        x.data = data;
        x.okv  = okv;
        q.push_back(x);
    endtask

    task automatic await_req(output ent_t x, output int cnt);
        cnt = 0;
        while (!bus.sd_rd && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("req_seen", 64'(bus.sd_rd), 64'(1));
        chk("sb_nonempty", 64'(q.size() != 0), 64'(1));
        x = q.pop_front();
        chk("sd_addr", 64'(bus.sd_addr), 64'(x.addr));
        chk("ok_pre", 64'(ok[x.slot]), 64'(0));
    endtask

    task automatic serve(input bit same, output int cnt);
        ent_t x;
        await_req(x, cnt);
        bus.sd_ack = 1'b1;
        if (same) begin
            bus.sd_rdy  = 1'b1;
            bus.sd_data = x.data;
        end
        @(negedge clk);
        bus.sd_ack = 1'b0;
        if (!same) begin
            chk("ok_wait", 64'(ok[x.slot]), 64'(0));
            bus.sd_rdy  = 1'b1;
            bus.sd_data = x.data;
            @(negedge clk);
        end
        bus.sd_rdy = 1'b0;
        chk("ok_vec", 64'(ok), 64'(x.okv));
        chk("data", 64'(dat[x.slot]), 64'(x.data));
        chk("sd_rd_low", 64'(bus.sd_rd), 64'(0));
    endtask

    initial begin
        {bus.r0_cs, bus.r1_cs, bus.r2_cs} = '0;
        {bus.r0_addr, bus.r1_addr, bus.r2_addr} = '0;
        {bus.sd_ack, bus.sd_rdy, bus.sd_data} = '0;
        repeat (2) @(negedge clk);
        chk("rst_rd", 64'(bus.sd_rd), 64'(0));
        chk("rst_addr", 64'(bus.sd_addr), 64'(0));
        chk("rst_ok", 64'(ok), 64'(0));
        chk("rst_data", {dat[0], dat[1] | dat[2]}, 64'(0));
        rst = 1'b0;
        @(negedge clk);
        // single miss on slot 1, minimum latency
        bus.r1_cs = 1'b1;
        bus.r1_addr = 18'h00123;
        push(2'd1, 22'h040123, 32'hDEADBEEF, 3'b010);
        serve(1'b0, n);
        chk("lat1", 64'(n), 64'(1));
        // held address hits without port traffic
        repeat (20) begin
            @(negedge clk);
            chk("hit_rd", 64'(bus.sd_rd), 64'(0));
            chk("hit_ok", 64'(ok[1]), 64'(1));
        end
        bus.r1_addr = 18'h00127;
        #1;
        chk("ok_drop", 64'(ok[1]), 64'(0));
        push(2'd1, 22'h040127, 32'h12345678, 3'b010);
        serve(1'b0, n);
        chk("lat2", 64'(n), 64'(1));
        // three simultaneous misses from pointer 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.r0_cs = 1'b1; bus.r0_addr = 18'h00010;
        bus.r1_addr = 18'h00020;
        bus.r2_cs = 1'b1; bus.r2_addr = 18'h00030;
        push(2'd1, 22'h040020, 32'hA1A1A1A1, 3'b010);
        push(2'd2, 22'h080030, 32'hA2A2A2A2, 3'b110);
        push(2'd0, 22'h000010, 32'hA0A0A0A0, 3'b111);
        repeat (3) serve(1'b0, n);
        // address change while slot 0 waits for data
        bus.r1_cs = 1'b0;
        bus.r2_cs = 1'b0;
        bus.r0_addr = 18'd5;
        push(2'd0, 22'h000005, 32'hA5A50005, 3'b000);
        await_req(e, n);
        bus.sd_ack = 1'b1;
        @(negedge clk);
        bus.sd_ack = 1'b0;
        bus.r0_addr = 18'd9;
        bus.sd_rdy = 1'b1;
        bus.sd_data = e.data;
        @(negedge clk);
        bus.sd_rdy = 1'b0;
        chk("stale_ok", 64'(ok), 64'(0));
        chk("stale_data", 64'(dat[0]), 64'(32'hA5A50005));
        bus.r0_addr = 18'd5;
        #1;
        chk("stale_caddr", 64'(ok), 64'(3'b001));
        bus.r0_addr = 18'd9;
        push(2'd0, 22'h000009, 32'hA5A50009, 3'b001);
        serve(1'b0, n);
        chk("lat_refetch", 64'(n), 64'(1));
        // ack and rdy together, then a stray rdy in IDLE
        bus.r2_cs = 1'b1;
        bus.r2_addr = 18'h3FFFF;
        push(2'd2, 22'h0BFFFF, 32'hC0FFEE02, 3'b101);
        serve(1'b1, n);
        chk("lat_same", 64'(n), 64'(1));
        @(negedge clk);
        bus.sd_rdy = 1'b1;
        bus.sd_data = 32'hBAD0BAD0;
        @(negedge clk);
        bus.sd_rdy = 1'b0;
        chk("idle_rdy_data", 64'(dat[2]), 64'(32'hC0FFEE02));
        chk("idle_rdy_rd", 64'(bus.sd_rd), 64'(0));
        chk("idle_rdy_ok", 64'(ok), 64'(3'b101));
        // asynchronous reset in WAIT, then a late rdy
        bus.r0_addr = 18'h00077;
        push(2'd0, 22'h000077, 32'h77777777, 3'b000);
        await_req(e, n);
        bus.sd_ack = 1'b1;
        @(negedge clk);
        bus.sd_ack = 1'b0;
        chk("pre_rst_ok", 64'(ok), 64'(3'b100));
        #2 rst = 1'b1;
        #1;
        chk("arst_rd", 64'(bus.sd_rd), 64'(0));
        chk("arst_ok", 64'(ok), 64'(0));
        {bus.r0_cs, bus.r1_cs, bus.r2_cs} = '0;
        @(negedge clk);
        rst = 1'b0;
        bus.sd_rdy = 1'b1;
        bus.sd_data = e.data;
        repeat (2) @(negedge clk);
        bus.sd_rdy = 1'b0;
        chk("late_rd", 64'(bus.sd_rd), 64'(0));
        chk("late_addr", 64'(bus.sd_addr), 64'(0));
        bus.r0_cs = 1'b1;
        bus.r2_cs = 1'b1;
        #1;
        chk("late_ok", 64'(ok), 64'(0));
        chk("late_data", {dat[0], dat[2]}, 64'(0));
        chk("sb_drained", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
